// File: rtl/rs_issue_scheduler_pkg.sv
// Shared sizing and entry layout for the reservation-station issue scheduler.
package rs_pkg;

    localparam int RS_SIZE     = 4;
    localparam int INSTR_WIDTH = 32;
    localparam int REG_W       = 5;
    localparam int SLOT_W      = $clog2(RS_SIZE);

    typedef struct packed {
        logic                   valid;
        logic [INSTR_WIDTH-1:0] instr;
        logic [REG_W-1:0]       s1;
        logic [REG_W-1:0]       s2;
        logic                   r1;
        logic                   r2;
    } rs_entry;

endpackage

// File: rtl/rs_issue_scheduler_if.sv
// Queue-side, CDB-side and FU-side signals of the issue scheduler, bundled.
interface rs_issue_scheduler_if;
    import rs_pkg::*;

    logic                   write;
    logic [INSTR_WIDTH-1:0] instr_in;
    logic [REG_W-1:0]       src1;
    logic [REG_W-1:0]       src2;
    logic                   src1_rdy;
    logic                   src2_rdy;
    logic                   cdb_valid;
    logic [REG_W-1:0]       cdb_reg;
    logic                   fu_ready;
    logic                   flush;
    logic                   stall;
    logic                   issue_valid;
    logic [INSTR_WIDTH-1:0] issue_instr;
    logic [SLOT_W-1:0]      issue_slot;
    logic [SLOT_W:0]        occupancy;
    logic                   overflow;

    modport master (
        output write, instr_in, src1, src2, src1_rdy, src2_rdy,
               cdb_valid, cdb_reg, fu_ready, flush,
        input  stall, issue_valid, issue_instr, issue_slot, occupancy, overflow
    );

    modport slave (
        input  write, instr_in, src1, src2, src1_rdy, src2_rdy,
               cdb_valid, cdb_reg, fu_ready, flush,
        output stall, issue_valid, issue_instr, issue_slot, occupancy, overflow
    );

endinterface

// File: rtl/rs_issue_scheduler_rr_select.sv
// Round-robin picker: first requesting slot at or after rr_ptr, wrapping.
module rr_select
    import rs_pkg::*;
(
    input  logic [RS_SIZE-1:0] req,
    input  logic [SLOT_W-1:0]  rr_ptr,
    output logic               grant_valid,
    output logic [SLOT_W-1:0]  grant_idx
);

    logic [SLOT_W-1:0] cand;

    // RS_SIZE is a power of two, so the SLOT_W-bit add wraps modulo RS_SIZE.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = rr_ptr;
        cand        = rr_ptr;
        for (int k = 0; k < RS_SIZE; k++) begin
            cand = rr_ptr + SLOT_W'(k);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rs_issue_scheduler.sv
// Reservation-station allocator with CDB wakeup and round-robin issue to one FU.
module rs_issue_scheduler
    import rs_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    rs_issue_scheduler_if.slave bus
);

    rs_entry                ent [RS_SIZE];
    logic [SLOT_W-1:0]      rr_ptr;
    logic [SLOT_W:0]        occ;
    logic                   iss_valid;
    logic [INSTR_WIDTH-1:0] iss_instr;
    logic [SLOT_W-1:0]      iss_slot;
    logic                   ovf;

    logic                   free_found;
    logic [SLOT_W-1:0]      free_idx;
    logic [RS_SIZE-1:0]     req;
    logic                   grant_valid;
    logic [SLOT_W-1:0]      grant_idx;
    logic                   issue_fire;
    logic                   alloc_fire;
    rs_entry                new_ent;

    // Lowest-index free entry, judged on pre-edge state so a slot freed by
    // this cycle's issue cannot be reused until the next cycle.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!ent[i].valid) begin
                free_found = 1'b1;
                free_idx   = SLOT_W'(i);
            end
        end
    end

    always_comb begin
        req = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            req[i] = ent[i].valid & ent[i].r1 & ent[i].r2;
        end
    end

    rr_select u_rr_select (
        .req         (req),
        .rr_ptr      (rr_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign issue_fire = bus.fu_ready & grant_valid;
    assign alloc_fire = bus.write & free_found;

    // Same-cycle CDB bypass for the allocating instruction's operands.
    always_comb begin
        new_ent       = '0;
        new_ent.valid = 1'b1;
        new_ent.instr = bus.instr_in;
        new_ent.s1    = bus.src1;
        new_ent.s2    = bus.src2;
        new_ent.r1    = bus.src1_rdy | (bus.src1 == '0) |
                        (bus.cdb_valid & (bus.cdb_reg == bus.src1));
        new_ent.r2    = bus.src2_rdy | (bus.src2 == '0) |
                        (bus.cdb_valid & (bus.cdb_reg == bus.src2));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent[i] <= '0;
            end
            rr_ptr    <= '0;
            occ       <= '0;
            iss_valid <= 1'b0;
            iss_instr <= '0;
            iss_slot  <= '0;
            ovf       <= 1'b0;
        end else if (bus.flush) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent[i].valid <= 1'b0;
            end
            rr_ptr    <= '0;
            occ       <= '0;
            iss_valid <= 1'b0;
            iss_instr <= '0;
            ovf       <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (ent[i].valid && bus.cdb_valid && (bus.cdb_reg == ent[i].s1)) begin
                    ent[i].r1 <= 1'b1;
                end
                if (ent[i].valid && bus.cdb_valid && (bus.cdb_reg == ent[i].s2)) begin
                    ent[i].r2 <= 1'b1;
                end
            end

            if (issue_fire) begin
                ent[grant_idx].valid <= 1'b0;
                iss_valid            <= 1'b1;
                iss_instr            <= ent[grant_idx].instr;
                iss_slot             <= grant_idx;
                rr_ptr               <= grant_idx + SLOT_W'(1);
            end else begin
                iss_valid <= 1'b0;
                iss_instr <= '0;
            end

            // Alloc targets an invalid slot and issue a valid one, so they never collide.
            if (alloc_fire) begin
                ent[free_idx] <= new_ent;
            end else if (bus.write) begin
                ovf <= 1'b1;
            end

            case ({alloc_fire, issue_fire})
                2'b10:   occ <= occ + (SLOT_W+1)'(1);
                2'b01:   occ <= occ - (SLOT_W+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign bus.stall       = (occ >= (SLOT_W+1)'(RS_SIZE - 1));
    assign bus.issue_valid = iss_valid;
    assign bus.issue_instr = iss_instr;
    assign bus.issue_slot  = iss_slot;
    assign bus.occupancy   = occ;
    assign bus.overflow    = ovf;

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Self-checking bench: directed vector table, hand sequences, random vs. model.
module tb_rs_issue_scheduler;
    import rs_pkg::*;

    localparam int N = RS_SIZE;

    logic clk;
    logic reset;
    rs_issue_scheduler_if bus ();

    rs_issue_scheduler dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        wr;
        logic [31:0] instr;
        logic [4:0]  s1, s2;
        logic        r1, r2;
        logic        cv;
        logic [4:0]  cr;
        logic        fu, fl;
        logic        e_iv;
        logic [31:0] e_instr;
        logic [1:0]  e_slot;
        logic [2:0]  e_occ;
        logic        e_stall, e_ovf;
    } vec_t;

    vec_t vq[$];

    // Reference model: entries as plain arrays, occupancy derived by counting.
    bit          m_valid [N];
    logic [31:0] m_instr [N];
    int          m_s1 [N];
    int          m_s2 [N];
    bit          m_r1 [N];
    bit          m_r2 [N];
    int          m_rr;
    bit          m_iv;
    logic [31:0] m_io;
    int          m_slot;
    bit          m_ovf;

    function automatic int m_occ();
        int c = 0;
        for (int i = 0; i < N; i++) if (m_valid[i]) c++;
        return c;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_instr[i] = '0; m_s1[i] = 0; m_s2[i] = 0; m_r1[i] = 0; m_r2[i] = 0;
        end
        m_rr = 0; m_iv = 0; m_io = '0; m_slot = 0; m_ovf = 0;
    endtask

    task automatic m_step();
        int pick = -1;
        int fr = -1;
        for (int k = 0; k < N; k++) begin
            int j = (m_rr + k) % N;
            if (pick < 0 && m_valid[j] && m_r1[j] && m_r2[j]) pick = j;
        end
        for (int i = 0; i < N; i++) if (fr < 0 && !m_valid[i]) fr = i;
        if (bus.flush) begin
            for (int i = 0; i < N; i++) m_valid[i] = 0;
            m_rr = 0; m_iv = 0; m_io = '0; m_ovf = 0;
            return;
        end
        for (int i = 0; i < N; i++) begin
            if (m_valid[i] && bus.cdb_valid && int'(bus.cdb_reg) == m_s1[i]) m_r1[i] = 1;
            if (m_valid[i] && bus.cdb_valid && int'(bus.cdb_reg) == m_s2[i]) m_r2[i] = 1;
        end
        if (bus.fu_ready && pick >= 0) begin
            m_iv = 1; m_io = m_instr[pick]; m_slot = pick;
            m_valid[pick] = 0; m_rr = (pick + 1) % N;
        end else begin
            m_iv = 0; m_io = '0;
        end
        if (bus.write) begin
            if (fr >= 0) begin
                m_valid[fr] = 1; m_instr[fr] = bus.instr_in;
                m_s1[fr] = int'(bus.src1); m_s2[fr] = int'(bus.src2);
                m_r1[fr] = bus.src1_rdy || bus.src1 == 0 || (bus.cdb_valid && bus.cdb_reg == bus.src1);
                m_r2[fr] = bus.src2_rdy || bus.src2 == 0 || (bus.cdb_valid && bus.cdb_reg == bus.src2);
            end else begin
                m_ovf = 1;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".issue_valid"}, 32'(bus.issue_valid), 32'(m_iv));
        chk({tag, ".issue_instr"}, bus.issue_instr, m_io);
        chk({tag, ".issue_slot"},  32'(bus.issue_slot), 32'(m_slot));
        chk({tag, ".occupancy"},   32'(bus.occupancy), 32'(m_occ()));
        chk({tag, ".stall"},       32'(bus.stall), 32'((N - m_occ()) < 2));
        chk({tag, ".overflow"},    32'(bus.overflow), 32'(m_ovf));
    endtask

    task automatic drive(input logic wr, input logic [31:0] ins, input logic [4:0] s1, input logic [4:0] s2,
                         input logic r1, input logic r2, input logic cv, input logic [4:0] cr,
                         input logic fu, input logic fl);
        bus.write = wr; bus.instr_in = ins; bus.src1 = s1; bus.src2 = s2;
        bus.src1_rdy = r1; bus.src2_rdy = r2; bus.cdb_valid = cv; bus.cdb_reg = cr;
        bus.fu_ready = fu; bus.flush = fl;
    endtask

    task automatic step(input logic wr, input logic [31:0] ins, input logic [4:0] s1, input logic [4:0] s2,
                        input logic r1, input logic r2, input logic cv, input logic [4:0] cr,
                        input logic fu, input logic fl);
        drive(wr, ins, s1, s2, r1, r2, cv, cr, fu, fl);
        m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic wr, input logic [31:0] ins, input logic [4:0] s1, input logic [4:0] s2,
                       input logic r1, input logic r2, input logic cv, input logic [4:0] cr,
                       input logic fu, input logic fl,
                       input logic eiv, input logic [31:0] eins, input logic [1:0] eslot,
                       input logic [2:0] eocc, input logic est, input logic eovf);
        vec_t v;
        v.wr = wr; v.instr = ins; v.s1 = s1; v.s2 = s2; v.r1 = r1; v.r2 = r2;
        v.cv = cv; v.cr = cr; v.fu = fu; v.fl = fl;
        v.e_iv = eiv; v.e_instr = eins; v.e_slot = eslot; v.e_occ = eocc; v.e_stall = est; v.e_ovf = eovf;
        vq.push_back(v);
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        m_reset();

        //   wr ins           s1 s2 r1 r2 cv cr fu fl | iv instr        slot occ st ovf
        // single ready instruction: alloc edge, then issue edge
        add(1, 32'h012A4020,  9,10, 1, 1, 0, 0, 1, 0,   0, 0,            0, 1, 0, 0);
        add(0, 0,             0, 0, 0, 0, 0, 0, 1, 0,   1, 32'h012A4020, 0, 0, 0, 0);
        add(0, 0,             0, 0, 0, 0, 0, 0, 1, 1,   0, 0,            0, 0, 0, 0);
        // three waiting on r5, stall at occupancy 3, wake, issue 0,1,2
        add(1, 32'hA1,        5, 1, 0, 1, 0, 0, 1, 0,   0, 0,            0, 1, 0, 0);
        add(1, 32'hA2,        5, 1, 0, 1, 0, 0, 1, 0,   0, 0,            0, 2, 0, 0);
        add(1, 32'hA3,        5, 1, 0, 1, 0, 0, 1, 0,   0, 0,            0, 3, 1, 0);
        add(0, 0,             0, 0, 0, 0, 1, 5, 1, 0,   0, 0,            0, 3, 1, 0);
        add(0, 0,             0, 0, 0, 0, 0, 0, 1, 0,   1, 32'hA1,       0, 2, 0, 0);
        add(0, 0,             0, 0, 0, 0, 0, 0, 1, 0,   1, 32'hA2,       1, 1, 0, 0);
        add(0, 0,             0, 0, 0, 0, 0, 0, 1, 0,   1, 32'hA3,       2, 0, 0, 0);
        add(0, 0,             0, 0, 0, 0, 0, 0, 1, 0,   0, 0,            2, 0, 0, 0);
        // fill all four with FU blocked, overflow, then round-robin from rr_ptr=3
        add(1, 32'hC0,        1, 2, 1, 1, 0, 0, 0, 0,   0, 0,            2, 1, 0, 0);
        add(1, 32'hC1,        1, 2, 1, 1, 0, 0, 0, 0,   0, 0,            2, 2, 0, 0);
        add(1, 32'hC2,        1, 2, 1, 1, 0, 0, 0, 0,   0, 0,            2, 3, 1, 0);
        add(1, 32'hC3,        1, 2, 1, 1, 0, 0, 0, 0,   0, 0,            2, 4, 1, 0);
        add(1, 32'hDD,        1, 2, 1, 1, 0, 0, 0, 0,   0, 0,            2, 4, 1, 1);
        add(0, 0,             0, 0, 0, 0, 0, 0, 1, 0,   1, 32'hC3,       3, 3, 1, 1);
        add(0, 0,             0, 0, 0, 0, 0, 0, 1, 0,   1, 32'hC0,       0, 2, 0, 1);
        add(0, 0,             0, 0, 0, 0, 0, 0, 1, 0,   1, 32'hC1,       1, 1, 0, 1);
        add(0, 0,             0, 0, 0, 0, 0, 0, 1, 0,   1, 32'hC2,       2, 0, 0, 1);
        // same-cycle CDB bypass at allocation (src2=r0 is always ready)
        add(1, 32'hE7,        7, 0, 0, 0, 1, 7, 1, 0,   0, 0,            2, 1, 0, 1);
        add(0, 0,             0, 0, 0, 0, 0, 0, 1, 0,   1, 32'hE7,       0, 0, 0, 1);
        // alloc+issue together; freed slot only reusable next cycle
        add(1, 32'hF0,        1, 1, 1, 1, 0, 0, 0, 0,   0, 0,            0, 1, 0, 1);
        add(1, 32'hF1,        1, 1, 1, 1, 0, 0, 1, 0,   1, 32'hF0,       0, 1, 0, 1);
        add(1, 32'hF2,        1, 1, 1, 1, 0, 0, 1, 0,   1, 32'hF1,       1, 1, 0, 1);
        // flush beats a concurrent write and issue
        add(1, 32'hF3,        1, 1, 1, 1, 0, 0, 1, 1,   0, 0,            1, 0, 0, 0);
        add(0, 0,             0, 0, 0, 0, 0, 0, 1, 0,   0, 0,            1, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("reset.issue_valid", 32'(bus.issue_valid), 0);
        chk("reset.occupancy",   32'(bus.occupancy), 0);
        chk("reset.stall",       32'(bus.stall), 0);
        chk("reset.overflow",    32'(bus.overflow), 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            vec_t v = vq[i];
            string t = $sformatf("vec%0d", i);
            step(v.wr, v.instr, v.s1, v.s2, v.r1, v.r2, v.cv, v.cr, v.fu, v.fl);
            chk({t, ".issue_valid"}, 32'(bus.issue_valid), 32'(v.e_iv));
            chk({t, ".issue_instr"}, bus.issue_instr, v.e_instr);
            chk({t, ".issue_slot"},  32'(bus.issue_slot), 32'(v.e_slot));
            chk({t, ".occupancy"},   32'(bus.occupancy), 32'(v.e_occ));
            chk({t, ".stall"},       32'(bus.stall), 32'(v.e_stall));
            chk({t, ".overflow"},    32'(bus.overflow), 32'(v.e_ovf));
        end

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 3) != 0), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                 ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) == 0));
            chk_model($sformatf("rnd%0d", c));
        end

        // Reset mid-issue with three entries still parked.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 32'h100 + i, 1, 2, 1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("pre_rst.issue_valid", 32'(bus.issue_valid), 1);
        chk("pre_rst.occupancy",   32'(bus.occupancy), 3);
        #2;
        reset = 1'b0;
        m_reset();
        #1;
        chk("mid_rst.issue_valid", 32'(bus.issue_valid), 0);
        chk("mid_rst.issue_instr", bus.issue_instr, 0);
        chk("mid_rst.issue_slot",  32'(bus.issue_slot), 0);
        chk("mid_rst.occupancy",   32'(bus.occupancy), 0);
        chk("mid_rst.stall",       32'(bus.stall), 0);
        chk("mid_rst.overflow",    32'(bus.overflow), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        step(1, 32'h5A5A, 3, 4, 1, 1, 0, 0, 0, 0);
        chk_model("post_rst_alloc");
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk_model("post_rst_issue");
        chk("post_rst.issue_slot",  32'(bus.issue_slot), 0);
        chk("post_rst.issue_instr", bus.issue_instr, 32'h5A5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rs_issue_scheduler.md
Name: rs_issue_scheduler

Overview:
Reservation-station allocator and issue arbiter that sits between the instruction queue and a single functional unit.
- Accepts instructions on the queue's write/instr_out handshake and parks them in RS_SIZE entries.
- Wakes up source operands on CDB register broadcasts.
- Issues one operand-ready entry per cycle to the FU, with round-robin fairness.
- Drives the queue's stall input.

Parameters:
RS_SIZE, 4, number of reservation-station entries (power of 2, >=2)
INSTR_WIDTH, 32, instruction bit width
REG_W, 5, architectural register index width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
write  input  1  allocate request from instruction queue
instr_in  input  INSTR_WIDTH  instruction to allocate
src1, src2  input  REG_W each  source register indices of instr_in
src1_rdy, src2_rdy  input  1 each  source value already available at allocation
cdb_valid  input  1  result broadcast valid
cdb_reg  input  REG_W  destination register being broadcast
fu_ready  input  1  FU can accept an instruction this cycle
flush  input  1  synchronous clear of all entries (mispredict)
stall  output  1  back-pressure to instruction queue
issue_valid  output  1  issue_instr/issue_slot valid this cycle
issue_instr  output  INSTR_WIDTH  issued instruction
issue_slot  output  log2(RS_SIZE)  entry index issued
occupancy  output  log2(RS_SIZE)+1  number of valid entries
overflow  output  1  sticky error: write arrived with no free entry

Behaviour:
- Reset values: all entries invalid, rr_ptr=0, issue_valid=0, issue_instr=0, issue_slot=0, occupancy=0, overflow=0, stall=0.
- Per-entry state: valid, instr, s1, s2, r1, r2.
- stall is combinational: 1 when free entries < 2, i.e. occupancy >= RS_SIZE-1.
  - The queue's write is registered one cycle after it samples stall, so one slot of slack is mandatory.
- Allocation, at the clock edge when write=1:
  - Takes the lowest-index entry that is invalid at the start of the cycle.
  - r1 = src1_rdy | (src1==0) | (cdb_valid & cdb_reg==src1); r2 is computed the same way.
- No free entry on write: the instruction is dropped, overflow<=1 (sticky until reset/flush), state is otherwise unchanged.
- Wakeup: every valid entry with cdb_valid & cdb_reg==sK sets rK<=1 at the edge.
- Eligibility: entry_rdy = valid & r1 & r2, evaluated on current (pre-edge) state.
  - An entry allocated or woken in cycle N is eligible no earlier than cycle N+1.
- Selection: the first eligible entry scanning rr_ptr, rr_ptr+1, ... modulo RS_SIZE.
- Issue, at the edge when fu_ready=1 and an eligible entry exists:
  - issue_valid<=1, issue_instr<=entry.instr, issue_slot<=index.
  - The entry is invalidated.
  - rr_ptr<=(index+1) mod RS_SIZE.
- Otherwise: issue_valid<=0, issue_instr<=0, issue_slot holds, rr_ptr holds.
- Issue latency: one cycle from eligibility+fu_ready to issue_valid.
- Simultaneous alloc and issue in the same cycle:
  - Both happen.
  - The slot freed by issue is not reusable until the next cycle.
  - occupancy is unchanged (+1-1).
- occupancy updates: +1 on alloc, -1 on issue, same edge as the entry state change. Wrap is impossible by construction.
- flush (synchronous, priority over write/issue/wakeup):
  - All entries invalid, occupancy=0, issue_valid=0, issue_instr=0, overflow=0.
  - rr_ptr=0.
- reset asserted mid-operation: immediate return to reset values; in-flight issue is lost.

Decomposition:
- Shared package rs_pkg: RS_SIZE, REG_W, INSTR_WIDTH defaults, SLOT_W=$clog2(RS_SIZE), and the rs_entry struct (valid, instr, s1, s2, r1, r2).
- One sub-module, rr_select: combinational round-robin picker.
  - Inputs: req vector [RS_SIZE], rr_ptr.
  - Outputs: grant_valid, grant_idx.
- The free-slot finder is a simple priority encoder, kept inline.

Test Plan:
1. Reset, then write instr 0x012A4020 with src1=9, src2=10, both rdy=1, fu_ready=1 -> issue_valid=1 two edges after the write edge (alloc edge, then issue edge), issue_slot=0, occupancy 0->1->0.
2. Allocate 3 entries with src1=5 not ready and src2 ready, fu_ready=1 -> stall=1 after the 3rd alloc (occupancy=3) and no issue. Then drive cdb_valid=1, cdb_reg=5 -> all three wake; issue order is slots 0,1,2 on consecutive cycles; stall drops when occupancy<=2.
3. Round-robin: slots 0..3 all ready, rr_ptr=2 -> issue order 2,3,0,1.
4. Same-cycle bypass: write with src1=7, src1_rdy=0, while cdb_valid=1, cdb_reg=7 -> entry allocated with r1=1 and issues one cycle later.
5. Overflow: fill to 4 entries with fu_ready=0, then write again -> overflow=1 and occupancy stays 4. flush -> occupancy=0, overflow=0, stall=0.
6. Reset asserted while issue_valid=1 and occupancy=3 -> all outputs 0 immediately. After release, first write of a ready instruction allocates slot 0.
